output_serializer: RTL and testbench

//   Parallel-to-serial stage directly upstream of the AP3 OUTPUT_IO cell. It accepts WIDTH-bit words

---
 rtl/output_serializer_pkg.sv | 15 +
 rtl/output_serializer.sv | 109 ++++++++++
 tb/tb_output_serializer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/output_serializer_pkg.sv
// Shared types and helpers for the output serializer ahead of the OUTPUT_IO cell.
package output_serializer_pkg;

  // Shifter control state; encoding is fixed so that SHIFT reads as 1 on a probe.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of the bit-position counter (0..width-1), never narrower than one bit.
  function automatic int cnt_bits(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/output_serializer.sv
// Parallel-to-serial stage feeding OUTPUT_IO.OQI. Words arrive over valid/ready, are shifted
// out one bit per IQC cycle, and a one-word hold buffer keeps consecutive words gap-free.
module output_serializer
  import output_serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             IQC,
  input  logic             QRT,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             OQI,
  output logic             busy,
  output logic             sof
);

  localparam int             CW   = cnt_bits(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  // Word widths outside the supported range are rejected at elaboration.
  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("output_serializer: WIDTH must lie in 2..32");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shifter;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;

  logic             accept;
  logic             load_slot;
  logic             take_hold;
  logic             take_input;
  logic             start_word;
  logic [WIDTH-1:0] load_word;

  // Bit that goes on the pin first for a given word.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return w[WIDTH-1];
    else           return w[0];
  endfunction

  // Word with its outgoing bit consumed, next bit moved to the output end.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return w << 1;
    else           return w >> 1;
  endfunction

  // Ready is dropped in reset and whenever the hold buffer is occupied, so an accept can never
  // collide with the hold-to-shifter transfer.
  assign ready_out  = QRT & ~hold_valid;
  assign accept     = valid_in & ready_out;
  assign busy       = (state == SHIFT);

  // The shifter can take a new word when idle or while its last bit is on the pin.
  assign load_slot  = (state == IDLE) | ((state == SHIFT) & (cnt == LAST));
  assign take_hold  = load_slot & hold_valid;
  assign take_input = load_slot & ~hold_valid & accept;
  assign start_word = take_hold | take_input;
  assign load_word  = hold_valid ? hold : data_in;

  // Control: state, bit counter, pin driver, start-of-frame pulse and hold occupancy.
  always_ff @(posedge IQC or negedge QRT) begin
    if (!QRT) begin
      state      <= IDLE;
      cnt        <= '0;
      OQI        <= IDLE_LEVEL;
      sof        <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      if (load_slot) begin
        cnt <= '0;
        if (start_word) begin
          state <= SHIFT;
          sof   <= 1'b1;
          OQI   <= first_bit(load_word);
          if (take_hold) hold_valid <= 1'b0;
        end else begin
          state <= IDLE;
          sof   <= 1'b0;
          OQI   <= IDLE_LEVEL;
        end
      end else begin
        cnt <= cnt + 1'b1;
        sof <= 1'b0;
        OQI <= first_bit(shifter);
      end
      // A word accepted while the shifter is mid-word parks in hold.
      if (accept && !load_slot) hold_valid <= 1'b1;
    end
  end

  // Data: shifter contents and the parked word; validity is tracked by the control block.
  always_ff @(posedge IQC) begin
    if (start_word) begin
      shifter <= advance(load_word);
    end else if (state == SHIFT) begin
      shifter <= advance(shifter);
    end
    if (accept && !load_slot) begin
      hold <= data_in;
    end
  end

endmodule

// File: tb/tb_output_serializer.sv
// Bench for output_serializer: reset, table of single words, back-to-back, LSB-first, reset
// mid-word, idle gap, and a randomized stream against a bit-queue reference model.
module tb_output_serializer;

  logic       IQC = 1'b0;
  logic       QRT = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, OQI, busy, sof;

  logic [7:0] d2_data = 8'h00;
  logic       d2_valid = 1'b0;
  logic       d2_ready, d2_oqi, d2_busy, d2_sof;

  int vectors     = 0;
  int miscompares = 0;

  always #5 IQC = ~IQC;

  output_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut (
    .IQC(IQC), .QRT(QRT), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .OQI(OQI), .busy(busy), .sof(sof)
  );

  output_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut2 (
    .IQC(IQC), .QRT(QRT), .data_in(d2_data), .valid_in(d2_valid),
    .ready_out(d2_ready), .OQI(d2_oqi), .busy(d2_busy), .sof(d2_sof)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of bits still owed to the pin. Each accepted word appends its
  // bits in transmit order; each clock edge puts the head bit on the pin. Ready is low while
  // a whole word beyond the one on the pin is queued.
  bit   q[$];
  bit   sq[$];
  logic exp_oqi, exp_sof, exp_busy;
  bit   last_acc;

  function automatic bit model_ready();
    return q.size() < 8;
  endfunction

  task automatic model_reset();
    q.delete();
    sq.delete();
    exp_oqi  = 1'b1;
    exp_sof  = 1'b0;
    exp_busy = 1'b0;
  endtask

  task automatic cycle(input logic v, input logic [7:0] w);
    bit acc;
    valid_in = v;
    data_in  = w;
    acc      = v && model_ready();
    last_acc = acc;
    if (acc) begin
      for (int i = 0; i < 8; i++) begin
        q.push_back(w[7-i]);
        sq.push_back(i == 0);
      end
    end
    @(posedge IQC);
    #1;
    if (q.size() > 0) begin
      exp_oqi  = q.pop_front();
      exp_sof  = sq.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_oqi  = 1'b1;
      exp_sof  = 1'b0;
      exp_busy = 1'b0;
    end
    check1("model_oqi", OQI, exp_oqi);
    check1("model_busy", busy, exp_busy);
    check1("model_sof", sof, exp_sof);
    check1("model_ready", ready_out, model_ready());
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] bits;  // pin sequence, leftmost bit sent first
  } vec_t;

  vec_t        tbl[5];
  logic [15:0] s, f, r;
  logic [17:0] g_o, g_b, g_s;
  logic [7:0]  w;
  bit          pend;

  initial begin
    tbl[0] = '{8'hA5, 8'b10100101};
    tbl[1] = '{8'h3C, 8'b00111100};
    tbl[2] = '{8'h00, 8'b00000000};
    tbl[3] = '{8'hFF, 8'b11111111};
    tbl[4] = '{8'h81, 8'b10000001};
    model_reset();

    // Reset held for three clocks
    repeat (3) @(posedge IQC);
    #1;
    check1("rst_oqi", OQI, 1'b1);
    check1("rst_ready", ready_out, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_sof", sof, 1'b0);
    check1("rst_d2_oqi", d2_oqi, 1'b0);
    QRT = 1'b1;
    #1;
    check1("rel_ready", ready_out, 1'b1);

    // Single words from the table
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 8; k++) begin
        cycle(k == 0, tbl[t].data);
        check1("tbl_bit", OQI, tbl[t].bits[7-k]);
        check1("tbl_sof", sof, k == 0);
      end
      cycle(1'b0, 8'h00);
      check1("tbl_idle_oqi", OQI, 1'b1);
      check1("tbl_idle_busy", busy, 1'b0);
    end

    // Back-to-back 0xA5, 0x3C
    for (int k = 0; k < 16; k++) begin
      cycle(k < 2, (k == 0) ? 8'hA5 : 8'h3C);
      s[15-k] = OQI;
      f[15-k] = sof;
      r[15-k] = ready_out;
    end
    checkv("b2b_stream", 32'(s), 32'h0000A53C);
    checkv("b2b_sof", 32'(f), 32'h00008080);
    checkv("b2b_ready", 32'(r), 32'h000080FF);

    // LSB first, idle low: 0x01
    d2_valid = 1'b1;
    d2_data  = 8'h01;
    @(posedge IQC);
    #1;
    check1("lsb_bit0", d2_oqi, 1'b1);
    check1("lsb_sof0", d2_sof, 1'b1);
    check1("lsb_busy0", d2_busy, 1'b1);
    d2_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(posedge IQC);
      #1;
      check1("lsb_bit", d2_oqi, 1'b0);
      check1("lsb_sof", d2_sof, 1'b0);
    end
    @(posedge IQC);
    #1;
    check1("lsb_idle_oqi", d2_oqi, 1'b0);
    check1("lsb_idle_busy", d2_busy, 1'b0);
    check1("lsb_ready", d2_ready, 1'b1);

    // Reset mid-word with 0x00 parked in hold
    cycle(1'b1, 8'hFF);
    cycle(1'b1, 8'h00);
    cycle(1'b0, 8'h00);
    #2;
    QRT = 1'b0;
    #1;
    check1("amid_oqi", OQI, 1'b1);
    check1("amid_busy", busy, 1'b0);
    check1("amid_ready", ready_out, 1'b0);
    check1("amid_sof", sof, 1'b0);
    model_reset();
    @(posedge IQC);
    #1;
    QRT = 1'b1;
    #1;
    check1("amid_rel_ready", ready_out, 1'b1);
    for (int k = 0; k < 16; k++) begin
      cycle(k == 0, 8'h0F);
      s[15-k] = OQI;
    end
    checkv("amid_after", 32'(s), 32'h00000FFF);

    // Two idle cycles between 0x81 and 0x7E
    for (int k = 0; k < 18; k++) begin
      cycle((k == 0) || (k == 10), (k == 10) ? 8'h7E : 8'h81);
      g_o[17-k] = OQI;
      g_b[17-k] = busy;
      g_s[17-k] = sof;
    end
    checkv("gap_oqi", 32'(g_o), 32'({8'h81, 2'b11, 8'h7E}));
    checkv("gap_busy", 32'(g_b), 32'({8'hFF, 2'b00, 8'hFF}));
    checkv("gap_sof", 32'(g_s), 32'({8'h80, 2'b00, 8'h80}));

    // Randomized stream with occasional asynchronous reset
    pend = 1'b0;
    w    = 8'h00;
    for (int n = 0; n < 2000; n++) begin
      if (!pend && $urandom_range(3) != 0) begin
        pend = 1'b1;
        w    = 8'($urandom);
      end
      if ($urandom_range(249) == 0) begin
        #2;
        QRT = 1'b0;
        #1;
        check1("rnd_rst_oqi", OQI, 1'b1);
        check1("rnd_rst_busy", busy, 1'b0);
        model_reset();
        pend     = 1'b0;
        valid_in = 1'b0;
        @(posedge IQC);
        #1;
        QRT = 1'b1;
      end else begin
        cycle(pend, w);
        if (last_acc) pend = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
